// File: rtl/serial_master_port.sv
// serial_master_port: bus initiator that serialises address, burst length and write data
// bit by bit toward a slave port and reassembles the serial read data coming back.
module serial_master_port #(
    parameter int ADDR_W  = 12,
    parameter int LEN_W   = 4,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              done,
    output logic              error,
    output logic              read_enable,
    output logic              write_enable,
    output logic              m_valid,
    output logic              m_ready,
    output logic              tx_address,
    output logic              tx_burst,
    output logic              tx_data,
    input  logic              s_ready,
    input  logic              s_valid,
    input  logic              rx_data,
    input  logic              split_enable
);
    localparam int AI_W = (ADDR_W > 1) ? $clog2(ADDR_W) : 1;
    localparam int DI_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int TO_W = $clog2(TIMEOUT + 1);
    localparam logic [AI_W-1:0] ADDR_LAST = AI_W'(ADDR_W - 1);
    localparam logic [DI_W-1:0] DATA_LAST = DI_W'(DATA_W - 1);
    localparam logic [TO_W-1:0] TOUT_LAST = TO_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, REQ, ADDR, WDATA, RDATA, SPLIT, DONE} state_t;
    state_t state, state_next;

    logic              is_write;
    logic [ADDR_W-1:0] addr_reg;
    logic [LEN_W-1:0]  len_reg;
    logic [ADDR_W-1:0] burst_pad;
    logic [AI_W-1:0]   addr_idx;
    logic [DI_W-1:0]   data_idx;
    logic [LEN_W-1:0]  beat_cnt;
    logic [TO_W-1:0]   tout_cnt;
    logic [DATA_W-1:0] shifter;
    logic [DATA_W-1:0] rx_word;
    logic              loaded;

    logic cmd_fire, addr_fire, addr_last, tout_wait, tout_hit;
    logic wr_load, wbit_fire, rbit_fire, bit_last, beat_last;

    // The burst field is shorter than the address, so it is zero-padded to share the bit index
    assign burst_pad = {{(ADDR_W-LEN_W){1'b0}}, len_reg};

    assign cmd_fire  = (state == IDLE) && cmd_valid;
    assign addr_fire = (state == ADDR) && s_ready;
    assign addr_last = addr_fire && (addr_idx == ADDR_LAST);
    assign tout_wait = (state == ADDR) && (addr_idx == '0) && !s_ready;
    assign tout_hit  = tout_wait && (tout_cnt == TOUT_LAST);
    assign wr_load   = (state == WDATA) && !loaded && wr_valid;
    assign wbit_fire = (state == WDATA) && loaded && s_ready;
    assign rbit_fire = (state == RDATA) && s_valid;
    assign bit_last  = (data_idx == DATA_LAST);
    assign beat_last = (beat_cnt == len_reg);

    always_comb begin
        rx_word           = shifter;
        rx_word[data_idx] = rx_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (cmd_fire) state_next = REQ;
            REQ:   state_next = ADDR;
            ADDR: begin
                if (tout_hit)       state_next = IDLE;
                else if (addr_last) state_next = is_write ? WDATA : RDATA;
            end
            WDATA: if (wbit_fire && bit_last && beat_last) state_next = DONE;
            // A bit arriving together with split_enable is taken and the split is ignored
            RDATA: begin
                if (rbit_fire) begin
                    if (bit_last && beat_last) state_next = DONE;
                end else if (split_enable) begin
                    state_next = SPLIT;
                end
            end
            SPLIT: if (!split_enable) state_next = RDATA;
            DONE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready    = (state == IDLE);
        done         = (state == DONE);
        read_enable  = 1'b0;
        write_enable = 1'b0;
        m_valid      = 1'b0;
        m_ready      = (state == RDATA);
        wr_ready     = (state == WDATA) && !loaded;
        tx_address   = 1'b0;
        tx_burst     = 1'b0;
        tx_data      = 1'b0;
        if (state inside {REQ, ADDR, WDATA, RDATA, SPLIT}) begin
            read_enable  = !is_write;
            write_enable = is_write;
        end
        if (state == ADDR) begin
            m_valid    = 1'b1;
            tx_address = addr_reg[addr_idx];
            tx_burst   = burst_pad[addr_idx];
        end
        if ((state == WDATA) && loaded) begin
            m_valid = 1'b1;
            tx_data = shifter[data_idx];
        end
    end

    // Datapath: command latch, bit/beat counters, shared shift register and pulse outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            is_write <= 1'b0;
            addr_reg <= '0;
            len_reg  <= '0;
            addr_idx <= '0;
            data_idx <= '0;
            beat_cnt <= '0;
            tout_cnt <= '0;
            shifter  <= '0;
            loaded   <= 1'b0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            error    <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            error    <= tout_hit;
            if (cmd_fire) begin
                is_write <= cmd_write;
                addr_reg <= cmd_addr;
                len_reg  <= cmd_len;
                addr_idx <= '0;
                data_idx <= '0;
                beat_cnt <= '0;
                tout_cnt <= '0;
                loaded   <= 1'b0;
            end
            if (addr_fire) begin
                addr_idx <= addr_last ? '0 : addr_idx + 1'b1;
            end
            if (tout_wait) begin
                tout_cnt <= tout_cnt + 1'b1;
            end
            if (wr_load) begin
                shifter  <= wr_data;
                loaded   <= 1'b1;
                data_idx <= '0;
            end
            if (wbit_fire) begin
                if (bit_last) begin
                    loaded   <= 1'b0;
                    data_idx <= '0;
                    beat_cnt <= beat_cnt + 1'b1;
                end else begin
                    data_idx <= data_idx + 1'b1;
                end
            end
            if (rbit_fire) begin
                shifter <= rx_word;
                if (bit_last) begin
                    data_idx <= '0;
                    beat_cnt <= beat_cnt + 1'b1;
                    rd_data  <= rx_word;
                    rd_valid <= 1'b1;
                end else begin
                    data_idx <= data_idx + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_master_port.sv
// tb_serial_master_port: drives directed and random transactions through serial_master_port
// while acting as the slave, and compares the captured serial streams with the commands issued.
module tb_serial_master_port;
    localparam int ADDR_W  = 12;
    localparam int LEN_W   = 4;
    localparam int DATA_W  = 8;
    localparam int TIMEOUT = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              cmd_valid, cmd_ready, cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [LEN_W-1:0]  cmd_len;
    logic [DATA_W-1:0] wr_data, rd_data;
    logic              wr_valid, wr_ready, rd_valid, done, error;
    logic              read_enable, write_enable, m_valid, m_ready;
    logic              tx_address, tx_burst, tx_data;
    logic              s_ready, s_valid, rx_data, split_enable;

    serial_master_port #(
        .ADDR_W(ADDR_W), .LEN_W(LEN_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .done(done), .error(error),
        .read_enable(read_enable), .write_enable(write_enable),
        .m_valid(m_valid), .m_ready(m_ready),
        .tx_address(tx_address), .tx_burst(tx_burst), .tx_data(tx_data),
        .s_ready(s_ready), .s_valid(s_valid), .rx_data(rx_data), .split_enable(split_enable)
    );

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    int n_checks = 0;
    int n_fail   = 0;

    // Slave/client behaviour knobs
    int p_sready, p_svalid, wr_delay, split_at, split_len, combo_at, rst_at_bit;
    bit cmd_noise, split_noise;
    logic [DATA_W-1:0] beats [16];

    // Observations of the last transaction
    int   done_cnt, done_cyc, err_cnt, err_cyc, we_first, we_last, re_first, re_last;
    int   first_wrr, viol;
    logic cmd_ready_at_err;
    bit   addr_q[$], burst_q[$], data_q[$];
    logic [DATA_W-1:0] rd_q[$];

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic setDefaults();
        p_sready    = 100;
        p_svalid    = 100;
        wr_delay    = 0;
        split_at    = -1;
        split_len   = 0;
        combo_at    = -1;
        rst_at_bit  = -1;
        cmd_noise   = 0;
        split_noise = 0;
    endtask

    task automatic idleInputs();
        cmd_valid    = 1'b0;
        cmd_write    = 1'b0;
        cmd_addr     = '0;
        cmd_len      = '0;
        wr_data      = '0;
        wr_valid     = 1'b0;
        s_ready      = 1'b0;
        s_valid      = 1'b0;
        rx_data      = 1'b0;
        split_enable = 1'b0;
    endtask

    // Issues one command and plays slave/client until done, error, reset hook or cycle bound
    task automatic applyStimulus(input logic wr, input logic [ADDR_W-1:0] addr,
                                 input logic [LEN_W-1:0] len);
        int cyc, rx_ptr, total_rx, wbeat, wr_wait, ep_left;
        bit ep_started, combo_used, in_split, resume_due, combo_due, finished;
        logic [DATA_W-1:0] bt;
        addr_q.delete(); burst_q.delete(); data_q.delete(); rd_q.delete();
        done_cnt = 0; done_cyc = -1; err_cnt = 0; err_cyc = -1;
        we_first = -1; we_last = -1; re_first = -1; re_last = -1;
        first_wrr = -1; viol = 0; cmd_ready_at_err = 1'b0;
        rx_ptr = 0; wbeat = 0; wr_wait = 0; ep_left = 0;
        ep_started = 0; combo_used = 0; in_split = 0; resume_due = 0; combo_due = 0;
        finished = 0;
        total_rx = wr ? 0 : (int'(len) + 1) * DATA_W;

        @(negedge clk);
        checkOutput("cmd_ready_idle", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_len = len;
        cyc = 0;
        while (!finished && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (write_enable) begin if (we_first < 0) we_first = cyc; we_last = cyc; end
            if (read_enable)  begin if (re_first < 0) re_first = cyc; re_last = cyc; end
            if (wr_ready && first_wrr < 0) first_wrr = cyc;
            if (rd_valid) rd_q.push_back(rd_data);
            if (done)  begin done_cnt++; done_cyc = cyc; finished = 1; end
            if (error) begin err_cnt++; err_cyc = cyc; cmd_ready_at_err = cmd_ready; finished = 1; end
            if (!m_valid && (tx_address || tx_burst || tx_data)) viol++;
            if (m_valid && (wr_ready || m_ready)) viol++;
            if (in_split && m_ready) viol++;
            if ((resume_due || combo_due) && !m_ready) viol++;

            if (rst_at_bit >= 0 && m_ready && rx_ptr == rst_at_bit) begin
                rst = 1'b1;
                #1;
                checkOutput("rst_cmd_ready", cmd_ready, 1);
                checkOutput("rst_outputs_zero",
                            {read_enable, write_enable, m_valid, m_ready, done, error,
                             rd_valid, wr_ready, tx_address, tx_burst, tx_data}, 0);
                checkOutput("rst_rd_data", rd_data, 0);
                finished = 1;
                continue;
            end

            cmd_valid = cmd_noise && (m_valid || m_ready) && ($urandom_range(1, 0) == 1);
            s_ready   = ($urandom_range(99, 0) < p_sready);
            s_valid   = ($urandom_range(99, 0) < p_svalid);
            split_enable = wr && split_noise && ($urandom_range(3, 0) == 0);
            if (!wr) begin
                if (ep_left > 0) begin
                    split_enable = 1'b1; s_valid = 1'b0; ep_left--;
                end else if (split_at >= 0 && !ep_started && m_ready && rx_ptr == split_at) begin
                    ep_started = 1; ep_left = split_len - 1;
                    split_enable = 1'b1; s_valid = 1'b0;
                end else if (combo_at >= 0 && !combo_used && m_ready && rx_ptr == combo_at) begin
                    combo_used = 1; split_enable = 1'b1; s_valid = 1'b1;
                end
            end
            if (rx_ptr < total_rx) begin
                bt = beats[rx_ptr / DATA_W];
                rx_data = bt[rx_ptr % DATA_W];
            end else begin
                rx_data = 1'($urandom_range(1, 0));
            end
            wr_data = 8'($urandom);
            wr_valid = 1'b0;
            if (wr_ready) begin
                if (wr_wait >= wr_delay) begin
                    wr_valid = 1'b1; wr_data = beats[wbeat];
                end else begin
                    wr_wait++;
                end
            end

            if (wr_valid && wr_ready) begin wbeat++; wr_wait = 0; end
            if (m_valid && s_ready) begin
                if (addr_q.size() < ADDR_W) begin
                    addr_q.push_back(tx_address); burst_q.push_back(tx_burst);
                end else begin
                    data_q.push_back(tx_data);
                end
            end
            if (m_ready && s_valid) rx_ptr++;
            resume_due = in_split && !split_enable;
            combo_due  = m_ready && split_enable && s_valid && (rx_ptr < total_rx);
            in_split   = split_enable && ((m_ready && !s_valid) || in_split);
        end
        checkOutput("txn_within_bound", finished, 1);
        idleInputs();
        @(negedge clk);
        rst = 1'b0;
        checkOutput("back_to_idle", cmd_ready, 1);
        checkOutput("done_is_pulse", done, 0);
        checkOutput("error_is_pulse", error, 0);
    endtask

    // Compares the captured streams with what the command and beat table should have produced
    task automatic checkTransaction(input logic wr, input logic [ADDR_W-1:0] addr,
                                    input logic [LEN_W-1:0] len);
        logic [ADDR_W-1:0] a_got, b_got, b_exp;
        logic [DATA_W-1:0] w_got;
        int nbeats;
        nbeats = int'(len) + 1;
        a_got = '0; b_got = '0;
        for (int k = 0; k < addr_q.size() && k < ADDR_W; k++) begin
            a_got[k] = addr_q[k]; b_got[k] = burst_q[k];
        end
        b_exp = ADDR_W'(len);
        checkOutput("addr_bit_count", addr_q.size(), ADDR_W);
        checkOutput("addr_stream", a_got, addr);
        checkOutput("burst_stream", b_got, b_exp);
        if (wr) begin
            checkOutput("wdata_bit_count", data_q.size(), nbeats * DATA_W);
            for (int b = 0; b < nbeats && (b + 1) * DATA_W <= data_q.size(); b++) begin
                for (int k = 0; k < DATA_W; k++) w_got[k] = data_q[b * DATA_W + k];
                checkOutput($sformatf("wdata_beat%0d", b), w_got, beats[b]);
            end
            checkOutput("no_rd_valid_on_write", rd_q.size(), 0);
            checkOutput("no_read_enable_on_write", re_first, -1);
        end else begin
            checkOutput("rd_beat_count", rd_q.size(), nbeats);
            for (int b = 0; b < nbeats && b < rd_q.size(); b++)
                checkOutput($sformatf("rd_beat%0d", b), rd_q[b], beats[b]);
            checkOutput("no_wdata_on_read", data_q.size(), 0);
            checkOutput("no_write_enable_on_read", we_first, -1);
        end
        checkOutput("done_count", done_cnt, 1);
        checkOutput("error_count", err_cnt, 0);
        checkOutput("protocol_rules", viol, 0);
    endtask

    initial begin
        logic wr;
        logic [ADDR_W-1:0] addr;
        logic [LEN_W-1:0] len;
        int total;

        idleInputs();
        setDefaults();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("reset_cmd_ready", cmd_ready, 1);
        checkOutput("reset_outputs_zero",
                    {read_enable, write_enable, m_valid, m_ready, done, error,
                     rd_valid, wr_ready, tx_address, tx_burst, tx_data}, 0);
        checkOutput("reset_rd_data", rd_data, 0);
        rst = 1'b0;

        $display("[TB] single-beat write, no stalls");
        setDefaults();
        beats[0] = 8'h3C;
        applyStimulus(1'b1, 12'hA5C, 4'd0);
        checkTransaction(1'b1, 12'hA5C, 4'd0);
        checkOutput("t1_done_cycle", done_cyc, 23);
        checkOutput("t1_we_first", we_first, 1);
        checkOutput("t1_we_last", we_last, 22);
        checkOutput("t1_wr_ready_cycle", first_wrr, 14);

        $display("[TB] three-beat read, no stalls");
        setDefaults();
        beats[0] = 8'h11; beats[1] = 8'h22; beats[2] = 8'h33;
        applyStimulus(1'b0, 12'h3F0, 4'd2);
        checkTransaction(1'b0, 12'h3F0, 4'd2);
        checkOutput("t2_done_cycle", done_cyc, 38);
        checkOutput("t2_re_last", re_last, 37);

        $display("[TB] read with 20-cycle split and split/valid collision");
        setDefaults();
        beats[0] = 8'($urandom);
        split_at = 3; split_len = 20; combo_at = 5;
        applyStimulus(1'b0, 12'h123, 4'd0);
        checkTransaction(1'b0, 12'h123, 4'd0);
        checkOutput("t3_done_cycle", done_cyc, 43);

        $display("[TB] address timeout");
        setDefaults();
        p_sready = 0;
        applyStimulus(1'b1, 12'h5A5, 4'd3);
        checkOutput("t4_error_count", err_cnt, 1);
        checkOutput("t4_error_cycle", err_cyc, 18);
        checkOutput("t4_we_last", we_last, 17);
        checkOutput("t4_cmd_ready_at_error", cmd_ready_at_err, 1);
        checkOutput("t4_no_done", done_cnt, 0);
        checkOutput("t4_no_addr_bits", addr_q.size(), 0);

        $display("[TB] two-beat write, stalled slave and late client");
        setDefaults();
        p_sready = 50; wr_delay = 5;
        beats[0] = 8'($urandom); beats[1] = 8'($urandom);
        applyStimulus(1'b1, 12'hC3A, 4'd1);
        checkTransaction(1'b1, 12'hC3A, 4'd1);

        $display("[TB] reset during read, then a fresh read");
        setDefaults();
        beats[0] = 8'($urandom); beats[1] = 8'($urandom);
        rst_at_bit = 4;
        applyStimulus(1'b0, 12'h777, 4'd1);
        checkOutput("t6_no_done", done_cnt, 0);
        checkOutput("t6_no_rd_valid", rd_q.size(), 0);
        setDefaults();
        beats[0] = 8'($urandom); beats[1] = 8'($urandom);
        applyStimulus(1'b0, 12'h0E1, 4'd1);
        checkTransaction(1'b0, 12'h0E1, 4'd1);

        $display("[TB] random transactions");
        for (int t = 0; t < 20; t++) begin
            setDefaults();
            wr   = 1'($urandom_range(1, 0));
            addr = 12'($urandom);
            len  = 4'($urandom_range(7, 0));
            for (int b = 0; b < 16; b++) beats[b] = 8'($urandom);
            p_sready    = $urandom_range(100, 50);
            p_svalid    = $urandom_range(100, 40);
            wr_delay    = $urandom_range(3, 0);
            cmd_noise   = 1;
            split_noise = 1;
            total = (int'(len) + 1) * DATA_W;
            if ($urandom_range(1, 0) == 1) begin
                split_at  = $urandom_range(total - 1, 0);
                split_len = $urandom_range(10, 1);
            end
            if ($urandom_range(1, 0) == 1) combo_at = $urandom_range(total - 1, 0);
            repeat ($urandom_range(2, 0)) @(negedge clk);
            applyStimulus(wr, addr, len);
            checkTransaction(wr, addr, len);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
